// File: rtl/fir_tap_sched.sv
// Tap sequencer for a time-multiplexed FIR MAC: coefficient load strobes, sample ring write, per-tap read/MAC control.
// Optional macro FIR_SCHED_ERR_EN adds the sticky cload_err output.
module fir_tap_sched #(
  parameter int N_TAPS  = 16,
  parameter int ADDR_W  = 11,
  parameter int COEF_W  = 20,
  parameter int DIN_W   = 16,
  parameter int MAC_LAT = 2
) (
  input  logic              clk_fast,
  input  logic              resetn,
  input  logic              CLOAD,
  input  logic [ADDR_W-1:0] CADDR,
  input  logic [COEF_W-1:0] CIN,
  input  logic              valid_in,
  input  logic [DIN_W-1:0]  din,
  output logic              in_ready,
  output logic              cmem_we,
  output logic [ADDR_W-1:0] cmem_waddr,
  output logic [COEF_W-1:0] cmem_wdata,
  output logic              smem_we,
  output logic [ADDR_W-1:0] smem_waddr,
  output logic [DIN_W-1:0]  smem_wdata,
  output logic [ADDR_W-1:0] rd_coef_addr,
  output logic [ADDR_W-1:0] rd_samp_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              valid_out,
`ifdef FIR_SCHED_ERR_EN
  output logic              cload_err,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, FLUSH, DONE} state_t;

  localparam int FW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W:0]   N_EXT  = (ADDR_W+1)'(N_TAPS);
  localparam logic [FW-1:0]     F_LAST = FW'(MAC_LAT - 1);

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] k, nxt_k, wptr, base, nxt_base, samp_addr;
  logic [FW-1:0]     fcnt, nxt_fcnt;
  logic [ADDR_W:0]   diff;
  logic              accept, cap, caddr_ok;

  assign accept   = (state == IDLE) && !CLOAD && valid_in && in_ready;
  assign cap      = CLOAD && ((state == IDLE) || (state == LOAD));
  assign caddr_ok = {1'b0, CADDR} < N_EXT;

  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_fcnt  = fcnt;
    nxt_base  = accept ? wptr : base;
    case (state)
      IDLE:  if (CLOAD) nxt_state = LOAD;
             else if (accept) nxt_state = WRITE;
      LOAD:  if (!CLOAD) nxt_state = IDLE;
      WRITE: begin
        nxt_state = RUN;
        nxt_k     = '0;
      end
      RUN: begin
        if (k == K_LAST) begin
          nxt_state = FLUSH;
          nxt_k     = '0;
          nxt_fcnt  = '0;
        end else begin
          nxt_k = k + 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt == F_LAST) nxt_state = DONE;
        else nxt_fcnt = fcnt + 1'b1;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Ring read address (base - k) mod N_TAPS; add N_TAPS back on borrow so any tap count works.
  always_comb begin
    diff = {1'b0, nxt_base} - {1'b0, nxt_k};
    if (diff[ADDR_W]) diff = diff + N_EXT;
    samp_addr = diff[ADDR_W-1:0];
  end

  always_ff @(posedge clk_fast) begin
    if (!resetn) begin
      state        <= IDLE;
      k            <= '0;
      fcnt         <= '0;
      wptr         <= '0;
      base         <= '0;
      in_ready     <= 1'b0;
      cmem_we      <= 1'b0;
      cmem_waddr   <= '0;
      cmem_wdata   <= '0;
      smem_we      <= 1'b0;
      smem_waddr   <= '0;
      smem_wdata   <= '0;
      rd_coef_addr <= '0;
      rd_samp_addr <= '0;
      mac_en       <= 1'b0;
      acc_clr      <= 1'b0;
      valid_out    <= 1'b0;
      busy         <= 1'b0;
`ifdef FIR_SCHED_ERR_EN
      cload_err    <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      k     <= nxt_k;
      fcnt  <= nxt_fcnt;
      base  <= nxt_base;
      if (state == WRITE) wptr <= (wptr == K_LAST) ? '0 : wptr + 1'b1;

      cmem_we <= cap && caddr_ok;
      if (cap) begin
        cmem_waddr <= CADDR;
        cmem_wdata <= CIN;
      end

      smem_we <= accept;
      if (accept) begin
        smem_waddr <= wptr;
        smem_wdata <= din;
      end

      // Outputs are registered from the next state so they line up with the state they describe.
      mac_en       <= (nxt_state == RUN);
      acc_clr      <= (nxt_state == RUN) && (nxt_k == '0);
      rd_coef_addr <= (nxt_state == RUN) ? nxt_k : '0;
      rd_samp_addr <= (nxt_state == RUN) ? samp_addr : '0;
      valid_out    <= (nxt_state == DONE);
      busy         <= (nxt_state != IDLE);
      in_ready     <= (nxt_state == IDLE) && !CLOAD;
`ifdef FIR_SCHED_ERR_EN
      if ((CLOAD && !((state == IDLE) || (state == LOAD))) || (cap && !caddr_ok))
        cload_err <= 1'b1;
`endif
    end
  end

endmodule
